// File: rtl/fb_scanout_engine.sv
// rtl/fb_scanout_engine.sv - framebuffer RAM with clear engine, palette/plane select and 2-stage scan-out
// Sits between hvsync_generator and the RGB pins; sync outputs are realigned to the pixel latency.
module fb_scanout_engine #(
  parameter int H_BITS = 5,
  parameter int V_BITS = 7,
  parameter int D      = 8,
  parameter int A      = H_BITS + V_BITS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [8:0]   hpos,
  input  logic [8:0]   vpos,
  input  logic         display_on,
  input  logic         hsync_in,
  input  logic         vsync_in,
  input  logic [1:0]   mode,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [A-1:0] wr_addr,
  input  logic [D-1:0] wr_data,
  input  logic         pal_we,
  input  logic [2:0]   pal_idx,
  input  logic [2:0]   pal_rgb,
  input  logic         clear_start,
  input  logic [D-1:0] clear_value,
  output logic         busy,
  output logic         hsync,
  output logic         vsync,
  output logic [2:0]   rgb
);
  localparam int DEPTH = 1 << A;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]   state;
  logic [A-1:0] clr_ptr;
  logic [D-1:0] clr_val;
  logic [D-1:0] mem [DEPTH];
  logic [2:0]   pal [8];
  logic [A-1:0] rd_addr;
  logic [A-1:0] mem_waddr;
  logic [D-1:0] mem_wdata;
  logic         mem_we;
  logic [D-1:0] q;
  logic         don1;
  logic         hs1;
  logic         vs1;
  logic [2:0]   pix;
  logic         unused_bits;

  // Upper position bits are deliberately dropped so the image wraps.
  assign rd_addr     = {vpos[V_BITS-1:0], hpos[H_BITS-1:0]};
  assign unused_bits = ^{hpos, vpos, q};

  assign wr_ready = !reset && (state == ST_IDLE);
  assign busy     = !reset && (state == ST_CLEAR);

  // A write accepted alongside clear_start still lands; the clear then overwrites it.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (!reset) begin
      if (state == ST_CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr;
        mem_wdata = clr_val;
      end else if (wr_valid) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      clr_ptr <= '0;
      clr_val <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clear_start) begin
            clr_val <= clear_value;
            clr_ptr <= '0;
            state   <= ST_CLEAR;
          end
        end
        default: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (&clr_ptr) state <= ST_IDLE;
        end
      endcase
    end
  end

  // Non-blocking write and read in one block gives read-before-write on a collision.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (reset) q <= '0;
    else       q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) pal[i] <= 3'(i);
    end else if (pal_we) begin
      pal[pal_idx] <= pal_rgb;
    end
  end

  always_comb begin
    pix = 3'b000;
    case (mode)
      2'd0:    pix = q[2:0];
      2'd1:    pix = q[5:3];
      2'd2:    pix = pal[q[2:0]];
      default: pix = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      don1  <= 1'b0;
      hs1   <= 1'b0;
      vs1   <= 1'b0;
      rgb   <= 3'b000;
      hsync <= 1'b0;
      vsync <= 1'b0;
    end else begin
      don1  <= display_on;
      hs1   <= hsync_in;
      vs1   <= vsync_in;
      rgb   <= don1 ? pix : 3'b000;
      hsync <= hs1;
      vsync <= vs1;
    end
  end
endmodule

// File: tb/tb_fb_scanout_engine.sv
// tb/tb_fb_scanout_engine.sv - randomized and directed bench for fb_scanout_engine
// Reference model: plain memory/palette arrays plus the values in flight toward the pins.
module tb_fb_scanout_engine;
  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  hpos, vpos;
  logic        display_on, hsync_in, vsync_in;
  logic [1:0]  mode;
  logic        wr_valid, wr_ready;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic        pal_we;
  logic [2:0]  pal_idx, pal_rgb;
  logic        clear_start;
  logic [7:0]  clear_value;
  logic        busy, hsync, vsync;
  logic [2:0]  rgb;

  always #5 clk = ~clk;

  fb_scanout_engine dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .mode(mode),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb),
    .clear_start(clear_start), .clear_value(clear_value), .busy(busy),
    .hsync(hsync), .vsync(vsync), .rgb(rgb)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] mmem [4096];
  logic [2:0] mpal [8];
  int         clr_left = 0;
  int         clr_next = 0;
  logic [7:0] clr_word;
  logic [7:0] fly_q;
  logic       fly_don, fly_hs, fly_vs;

  function automatic logic [2:0] colour(input logic [1:0] md, input logic [7:0] word);
    int w = int'(word);
    case (md)
      2'd0:    return 3'(w % 8);
      2'd1:    return 3'((w / 8) % 8);
      2'd2:    return mpal[w % 8];
      default: return 3'd0;
    endcase
  endfunction

  // One clock edge with the currently driven inputs, then check every output.
  task automatic tick();
    logic [2:0] exp_rgb;
    logic       exp_hs, exp_vs;
    int         ra;
    if (reset) begin
      exp_rgb = 3'd0; exp_hs = 1'b0; exp_vs = 1'b0;
      fly_q = 8'd0; fly_don = 1'b0; fly_hs = 1'b0; fly_vs = 1'b0;
      for (int i = 0; i < 8; i++) mpal[i] = 3'(i);
      clr_left = 0;
    end else begin
      exp_rgb = fly_don ? colour(mode, fly_q) : 3'd0;
      exp_hs  = fly_hs;
      exp_vs  = fly_vs;
      ra      = (int'(vpos) % 128) * 32 + (int'(hpos) % 32);
      fly_q   = mmem[ra];
      fly_don = display_on; fly_hs = hsync_in; fly_vs = vsync_in;
      if (pal_we) mpal[pal_idx] = pal_rgb;
      if (clr_left > 0) begin
        mmem[clr_next] = clr_word;
        clr_next++;
        clr_left--;
      end else begin
        if (wr_valid) mmem[wr_addr] = wr_data;
        if (clear_start) begin
          clr_word = clear_value; clr_next = 0; clr_left = 4096;
        end
      end
    end
    @(posedge clk);
    #1;
    if (!$isunknown(exp_rgb)) check("rgb", 32'(rgb), 32'(exp_rgb));
    check("hsync", 32'(hsync), 32'(exp_hs));
    check("vsync", 32'(vsync), 32'(exp_vs));
    check("busy", 32'(busy), 32'(!reset && clr_left > 0));
    check("wr_ready", 32'(wr_ready), 32'(!reset && clr_left == 0));
  endtask

  task automatic write_word(input int addr, input logic [7:0] data);
    wr_valid = 1'b1; wr_addr = 12'(addr); wr_data = data;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic read_px(input int addr, input logic [1:0] md, input logic don, output logic [2:0] r);
    vpos = 9'(addr / 32); hpos = 9'(addr % 32); display_on = don;
    tick();
    mode = md; display_on = 1'b0;
    tick();
    r = rgb;
  endtask

  task automatic run_clear(input logic [7:0] val, input int poke_at, output int cycles);
    clear_start = 1'b1; clear_value = val;
    tick();
    clear_start = 1'b0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 5000) begin
      cycles++;
      if (cycles == poke_at) begin
        clear_start = 1'b1; clear_value = 8'hFF;
      end
      tick();
      clear_start = 1'b0;
    end
  endtask

  logic [2:0]  r;
  int          n;
  logic [11:0] pool [16];

  initial begin
    reset = 1'b1; hpos = '0; vpos = '0; display_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    mode = 2'd0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; pal_we = 1'b0; pal_idx = '0;
    pal_rgb = '0; clear_start = 1'b0; clear_value = '0;

    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_rgb", 32'(rgb), 0);
    end
    reset = 1'b0;
    tick();
    check("after_reset_wr_ready", 32'(wr_ready), 1);

    run_clear(8'h07, 1000, n);
    check("clear_cycles", n, 4096);
    for (int a = 0; a < 4096; a++) begin
      vpos = 9'(a / 32); hpos = 9'(a % 32); display_on = 1'b1; mode = 2'd0;
      tick();
    end
    display_on = 1'b0;
    tick();
    tick();
    read_px(4095, 2'd0, 1'b1, r);
    check("clear_last_word", 32'(r), 7);

    write_word(12'h041, 8'h2D);
    read_px(12'h041, 2'd0, 1'b1, r);
    check("plane0", 32'(r), 3'b101);
    read_px(12'h041, 2'd1, 1'b1, r);
    check("plane1", 32'(r), 3'b101);

    pal_we = 1'b1; pal_idx = 3'd5; pal_rgb = 3'b010;
    tick();
    pal_we = 1'b0;
    write_word(12'h123, 8'h05);
    read_px(12'h123, 2'd2, 1'b1, r);
    check("palette", 32'(r), 3'b010);
    read_px(12'h123, 2'd3, 1'b1, r);
    check("blank_mode", 32'(r), 0);
    read_px(12'h041, 2'd0, 1'b0, r);
    check("display_off", 32'(r), 0);

    wr_valid = 1'b1; wr_addr = 12'h000; wr_data = 8'h01;
    run_clear(8'h3C, 0, n);
    wr_valid = 1'b0;
    check("clear2_cycles", n, 4096);
    read_px(0, 2'd0, 1'b1, r);
    check("clear_beats_write", 32'(r), 3'b100);

    write_word(3 * 32 + 1, 8'h06);
    vpos = 9'd131; hpos = 9'd33; display_on = 1'b1;
    tick();
    display_on = 1'b0; mode = 2'd0;
    tick();
    check("pos_wrap", 32'(rgb), 3'b110);

    hsync_in = 1'b1; vsync_in = 1'b1;
    tick();
    hsync_in = 1'b0; vsync_in = 1'b0;
    check("hsync_not_early", 32'(hsync), 0);
    tick();
    check("hsync_delayed", 32'(hsync), 1);
    check("vsync_delayed", 32'(vsync), 1);
    tick();
    check("hsync_pulse_end", 32'(hsync), 0);

    clear_start = 1'b1; clear_value = 8'h11;
    tick();
    clear_start = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    reset = 1'b1;
    tick();
    check("reset_mid_clear_busy", 32'(busy), 0);
    reset = 1'b0;
    tick();
    check("idle_after_reset", 32'(wr_ready), 1);

    for (int i = 0; i < 16; i++) pool[i] = 12'($urandom);
    for (int i = 0; i < 3000; i++) begin
      int p = int'($urandom_range(0, 15));
      wr_valid = ($urandom % 3) == 0;
      wr_addr = pool[$urandom_range(0, 15)];
      wr_data = 8'($urandom);
      pal_we = ($urandom % 8) == 0;
      pal_idx = 3'($urandom); pal_rgb = 3'($urandom);
      mode = 2'($urandom);
      display_on = ($urandom % 4) != 0;
      hsync_in = 1'($urandom); vsync_in = 1'($urandom);
      hpos = 9'(int'(pool[p]) % 32 + 32 * int'($urandom_range(0, 15)));
      vpos = 9'(int'(pool[p]) / 32 + 128 * int'($urandom_range(0, 3)));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
